polyphase_interp_tx: RTL and testbench

//  Transmit-side polyphase upsampler and pulse shaper for the MSK modem.
//  - Accepts baseband I/Q symbols over a valid/ready handshake.
//  - Emits OSF shaped I/Q samples per symbol, one per samp_en_i strobe.
//  - Coefficient branch is selected by an internal phase counter 0..OSF-1.
//  - Sits between the symbol mapper and the DAC / channel model; feeds the receive interpolator in loopback.

---
 rtl/msk_tx_pkg.sv | 57 +++++
 rtl/polyphase_mac.sv | 53 +++++
 rtl/polyphase_interp_tx.sv | 147 ++++++++++++++
 tb/tb_polyphase_interp_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/msk_tx_pkg.sv
// Shared types, sizes and pulse table for the MSK transmit upsampler.
// Contents:
//   OSF / TAPS_PPH / WIQ / WO  - branch count, taps per branch, in/out widths
//   coef_t                     - Q1.15 signed coefficient
//   COEF[OSF][TAPS_PPH]        - half-sine MSK pulse split into polyphase rows
//   sat_round()                - round half-up, >>15, saturate to WO bits
package msk_tx_pkg;

  localparam int OSF      = 20;
  localparam int TAPS_PPH = 5;
  localparam int WIQ      = 16;
  localparam int WO       = 18;
  localparam int CW       = 16;
  localparam int PW       = WIQ + CW;
  localparam int AW       = PW + $clog2(TAPS_PPH);
  localparam int PHW      = $clog2(OSF);

  typedef logic signed [CW-1:0] coef_t;

  // h[n] = round(32767 * sin(pi*n/40)), n = 0..39, laid out as
  // COEF[p][k] = h[p + OSF*k]. The half-sine spans two symbols, so taps 2..4
  // are zero; the history depth is kept for longer pulses.
  localparam coef_t COEF [OSF][TAPS_PPH] = '{
    '{16'sd0,     16'sd32767, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd2571,  16'sd32666, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd5126,  16'sd32364, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd7649,  16'sd31862, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd10126, 16'sd31163, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd12539, 16'sd30273, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd14876, 16'sd29196, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd17121, 16'sd27938, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd19260, 16'sd26509, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd21280, 16'sd24916, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd23170, 16'sd23170, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd24916, 16'sd21280, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd26509, 16'sd19260, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd27938, 16'sd17121, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd29196, 16'sd14876, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd30273, 16'sd12539, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd31163, 16'sd10126, 16'sd0, 16'sd0, 16'sd0},
    '{16'sd31862, 16'sd7649,  16'sd0, 16'sd0, 16'sd0},
    '{16'sd32364, 16'sd5126,  16'sd0, 16'sd0, 16'sd0},
    '{16'sd32666, 16'sd2571,  16'sd0, 16'sd0, 16'sd0}
  };

  localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (WO-1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-(1 << (WO-1)));

  function automatic logic signed [WO-1:0] sat_round(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] r;
    r = (acc + AW'(1 << (CW-2))) >>> (CW-1);
    if (r > SAT_HI)      sat_round = SAT_HI[WO-1:0];
    else if (r < SAT_LO) sat_round = SAT_LO[WO-1:0];
    else                 sat_round = r[WO-1:0];
  endfunction

endpackage

// File: rtl/polyphase_mac.sv
// One rail (I or Q) of the polyphase filter: stage 1 registers the
// TAPS_PPH products, stage 2 registers the rounded/saturated sum.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en_i       load new products (one per output-rate strobe)
//   sum_en_i   stage-1 data is valid; update the output register
//   coef_i     coefficient row for the current phase
//   hist_i     symbol history (post-shift)
//   y_o        shaped sample, held while sum_en_i is low
module polyphase_mac
  import msk_tx_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en_i,
  input  logic                               sum_en_i,
  input  coef_t [TAPS_PPH-1:0]               coef_i,
  input  logic  [TAPS_PPH-1:0][WIQ-1:0]      hist_i,
  output logic signed [WO-1:0]               y_o
);

  logic [TAPS_PPH-1:0][PW-1:0] prod_q, prod_d;
  logic signed [WO-1:0]        y_q, y_d;
  logic signed [AW-1:0]        acc;

  always_comb begin
    prod_d = prod_q;
    if (en_i) begin
      for (int k = 0; k < TAPS_PPH; k++)
        prod_d[k] = PW'($signed(coef_i[k])) * PW'($signed(hist_i[k]));
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS_PPH; k++)
      acc = acc + AW'($signed(prod_q[k]));
    y_d = sum_en_i ? sat_round(acc) : y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      y_q    <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/polyphase_interp_tx.sv
// Transmit polyphase upsampler / MSK pulse shaper. Takes one I/Q symbol per
// OSF output strobes and emits one shaped sample per samp_en_i, 2 cycles later.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sym_i_i, sym_q_i    symbol in (signed WIQ)
//   sym_val_i/sym_rdy_o symbol handshake, one-entry holding register
//   samp_en_i           output-rate strobe
//   i_o, q_o, iq_val_o  shaped sample out (signed WO), held while not valid
//   underflow_o         sticky: phase 0 hit with no symbol held
//   sym_strobe_o        (TX_SYM_STROBE_EN only) marks the phase-0 sample
// Build option: define TX_SYM_STROBE_EN to add sym_strobe_o.
module polyphase_interp_tx
  import msk_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIQ-1:0]        sym_i_i,
  input  logic [WIQ-1:0]        sym_q_i,
  input  logic                  sym_val_i,
  output logic                  sym_rdy_o,
  input  logic                  samp_en_i,
  output logic signed [WO-1:0]  i_o,
  output logic signed [WO-1:0]  q_o,
  output logic                  iq_val_o,
  output logic                  underflow_o
`ifdef TX_SYM_STROBE_EN
  ,
  output logic                  sym_strobe_o
`endif
);

  localparam int STAGES = 2;

  logic [PHW-1:0]               phase_q, phase_d;
  logic                         held_q, held_d;
  logic [WIQ-1:0]               hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic [TAPS_PPH-1:0][WIQ-1:0] hist_i_q, hist_i_d, hist_q_q, hist_q_d;
  logic                         underflow_q, underflow_d;
  logic [STAGES:1]              vld_pipe_q, vld_pipe_d;
  logic [WIQ-1:0]               new_i, new_q;
  logic                         consume, accept;
  coef_t [TAPS_PPH-1:0]         coef_row;

  // The held symbol leaves on the phase-0 strobe, so a new one can be taken
  // in the same cycle.
  assign consume   = samp_en_i & (phase_q == '0);
  assign sym_rdy_o = ~rst & (~held_q | consume);
  assign accept    = sym_val_i & sym_rdy_o;

  // An empty holding register at phase 0 injects a zero symbol.
  assign new_i = held_q ? hold_i_q : '0;
  assign new_q = held_q ? hold_q_q : '0;

  always_comb begin
    phase_d     = phase_q;
    held_d      = held_q;
    hold_i_d    = hold_i_q;
    hold_q_d    = hold_q_q;
    hist_i_d    = hist_i_q;
    hist_q_d    = hist_q_q;
    underflow_d = underflow_q;
    vld_pipe_d  = {vld_pipe_q[STAGES-1:1], samp_en_i};

    if (samp_en_i)
      phase_d = (phase_q == PHW'(OSF-1)) ? '0 : phase_q + 1'b1;

    if (consume) begin
      hist_i_d = {hist_i_q[TAPS_PPH-2:0], new_i};
      hist_q_d = {hist_q_q[TAPS_PPH-2:0], new_q};
      held_d   = 1'b0;
      if (!held_q) underflow_d = 1'b1;
    end

    if (accept) begin
      held_d   = 1'b1;
      hold_i_d = sym_i_i;
      hold_q_d = sym_q_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      held_q      <= 1'b0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      hist_i_q    <= '0;
      hist_q_q    <= '0;
      underflow_q <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      phase_q     <= phase_d;
      held_q      <= held_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      hist_i_q    <= hist_i_d;
      hist_q_q    <= hist_q_d;
      underflow_q <= underflow_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS_PPH; k++)
      coef_row[k] = COEF[phase_q][k];
  end

  // Rails: 0 = I, 1 = Q. The MACs see the post-shift history so the phase-0
  // sample already includes the newest symbol.
  logic [1:0][TAPS_PPH-1:0][WIQ-1:0] hist_rail;
  logic [1:0][WO-1:0]                y_rail;

  assign hist_rail[0] = hist_i_d;
  assign hist_rail[1] = hist_q_d;

  for (genvar r = 0; r < 2; r++) begin : g_rail
    polyphase_mac u_mac (
      .clk      (clk),
      .rst      (rst),
      .en_i     (samp_en_i),
      .sum_en_i (vld_pipe_q[1]),
      .coef_i   (coef_row),
      .hist_i   (hist_rail[r]),
      .y_o      (y_rail[r])
    );
  end

  assign i_o         = y_rail[0];
  assign q_o         = y_rail[1];
  assign iq_val_o    = vld_pipe_q[STAGES];
  assign underflow_o = underflow_q;

`ifdef TX_SYM_STROBE_EN
  // Phase-0 marker rides alongside the valid pipe.
  logic [STAGES:1] strb_pipe_q, strb_pipe_d;

  assign strb_pipe_d = {strb_pipe_q[STAGES-1:1], consume};

  always_ff @(posedge clk) begin
    if (rst) strb_pipe_q <= '0;
    else     strb_pipe_q <= strb_pipe_d;
  end

  assign sym_strobe_o = strb_pipe_q[STAGES];
`endif

endmodule

// File: tb/tb_polyphase_interp_tx.sv
module tb_polyphase_interp_tx;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [15:0]        sym_i_i = '0, sym_q_i = '0;
  logic               sym_val_i = 1'b0, samp_en_i = 1'b0;
  logic               sym_rdy_o, iq_val_o, underflow_o;
  logic signed [17:0] i_o, q_o;
`ifdef TX_SYM_STROBE_EN
  logic               sym_strobe_o;
`endif

  polyphase_interp_tx dut (
    .clk(clk), .rst(rst), .sym_i_i(sym_i_i), .sym_q_i(sym_q_i),
    .sym_val_i(sym_val_i), .sym_rdy_o(sym_rdy_o), .samp_en_i(samp_en_i),
    .i_o(i_o), .q_o(q_o), .iq_val_o(iq_val_o), .underflow_o(underflow_o)
`ifdef TX_SYM_STROBE_EN
    , .sym_strobe_o(sym_strobe_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int i; int q; bit s; int cyc; } exp_t;
  exp_t expq[$];

  int  nchk = 0, nerr = 0, cyc = 0;
  int  coef [20][5];
  int  mphase = 0, mhi = 0, mhq = 0;
  bit  mheld = 0, munder = 0, m_in_rst = 1, m_rdy;
  int  mhist_i [5], mhist_q [5];
  int  last_i = 0, last_q = 0;
  int  dut_acc = 0;
  bit  imp_on = 0;
  int  imp_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int shape(input longint acc);
    longint r;
    r = (acc + 16384) >>> 15;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return int'(r);
  endfunction

  task automatic model_reset();
    mphase = 0; mheld = 0; munder = 0; mhi = 0; mhq = 0;
    for (int k = 0; k < 5; k++) begin mhist_i[k] = 0; mhist_q[k] = 0; end
    expq.delete();
    last_i = 0; last_q = 0;
  endtask

  // One clock of stimulus: drive at the falling edge, check handshake state,
  // then advance the reference model by what the next rising edge will do.
  task automatic step(input bit r, input bit sv, input int si, input int sq, input bit se);
    bit consume, accept;
    longint ai, aq;
    @(negedge clk);
    rst = r; sym_val_i = sv; sym_i_i = si[15:0]; sym_q_i = sq[15:0]; samp_en_i = se;
    #1;
    chk("underflow", underflow_o, munder);
    if (r) begin
      chk("rdy_in_reset", sym_rdy_o, 0);
      if (m_in_rst) chk("val_in_reset", iq_val_o, 0);
      model_reset();
      m_in_rst = 1;
    end else begin
      m_in_rst = 0;
      consume = se && (mphase == 0);
      m_rdy = !mheld || consume;
      chk("sym_rdy", sym_rdy_o, m_rdy);
      if (sv && sym_rdy_o) dut_acc++;
      accept = sv && m_rdy;
      if (consume) begin
        for (int k = 4; k > 0; k--) begin mhist_i[k] = mhist_i[k-1]; mhist_q[k] = mhist_q[k-1]; end
        mhist_i[0] = mheld ? mhi : 0;
        mhist_q[0] = mheld ? mhq : 0;
        if (!mheld) munder = 1;
        mheld = 0;
      end
      if (se) begin
        ai = 0; aq = 0;
        for (int k = 0; k < 5; k++) begin
          ai += longint'(coef[mphase][k]) * mhist_i[k];
          aq += longint'(coef[mphase][k]) * mhist_q[k];
        end
        expq.push_back('{shape(ai), shape(aq), consume, cyc + 2});
        mphase = (mphase == 19) ? 0 : mphase + 1;
      end
      if (accept) begin mheld = 1; mhi = si; mhq = sq; end
    end
  endtask

  // Monitor: pops one expectation per valid sample, checks hold otherwise.
  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (iq_val_o) begin
      if (expq.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        e = expq.pop_front();
        chk("sample_i", $signed(i_o), e.i);
        chk("sample_q", $signed(q_o), e.q);
        chk("latency", cyc, e.cyc);
`ifdef TX_SYM_STROBE_EN
        chk("sym_strobe", sym_strobe_o, e.s);
`endif
        last_i = e.i; last_q = e.q;
        if (imp_on) imp_log.push_back(int'($signed(i_o)));
      end
    end else begin
      chk("hold_i", $signed(i_o), last_i);
      chk("hold_q", $signed(q_o), last_q);
`ifdef TX_SYM_STROBE_EN
      chk("strobe_idle", sym_strobe_o, 0);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < 5; k++) coef[p][k] = 0;
      coef[p][0] = $rtoi(32767.0 * $sin(3.14159265358979 * p / 40.0) + 0.5);
      coef[p][1] = $rtoi(32767.0 * $sin(3.14159265358979 * (p + 20) / 40.0) + 0.5);
    end
    model_reset();

    // Reset with traffic, then traffic, then a 3-cycle reset mid-symbol.
    repeat (2) step(1, 1, 100, -100, 1);
    for (int n = 0; n < 30; n++) step(0, 1, (n + 1) * 300, -(n + 1) * 200, 1);
    repeat (3) step(1, 1, 777, 777, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("underflow_first_strobe", underflow_o, 1);

    // Impulse response.
    repeat (2) step(1, 0, 0, 0, 0);
    step(0, 1, 16384, 0, 0);
    imp_on = 1;
    for (int n = 0; n < 105; n++) step(0, 1, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 0);
    imp_on = 0;
    chk("impulse_count", imp_log.size(), 105);
    if (imp_log.size() >= 100) begin
      chk("imp_0",  imp_log[0],  0);
      chk("imp_5",  imp_log[5],  6270);
      chk("imp_10", imp_log[10], 11585);
      chk("imp_19", imp_log[19], 16333);
      chk("imp_20", imp_log[20], 16384);
      chk("imp_25", imp_log[25], 15137);
      chk("imp_39", imp_log[39], 1286);
      chk("imp_40", imp_log[40], 0);
      chk("imp_99", imp_log[99], 0);
    end
    chk("underflow_impulse", underflow_o, 0);

    // Backpressure: valid held high, one accept per 20 strobes.
    dut_acc = 0;
    for (int n = 0; n < 100; n++) step(0, 1, 1000 + 97 * n, -(2000 + 53 * n), 1);
    chk("accept_count", dut_acc, 5);

    // Sparse strobe every 7th cycle.
    for (int n = 0; n < 45; n++) begin
      step(0, 1, 3000 - 211 * n, 150 * n, 1);
      repeat (6) step(0, 1, 3000 - 211 * n, 150 * n, 0);
    end

    // Full-scale symbols. The half-sine rows sum to at most ~1.41, so the
    // output stays well inside 18 bits; the clip itself is driven directly.
    repeat (2) step(1, 0, 0, 0, 0);
    for (int n = 0; n < 60; n++) step(0, 1, 32767, -32768, 1);
    for (int n = 0; n < 60; n++) step(0, 1, -32768, 32767, 1);
    chk("sat_hi_huge", msk_tx_pkg::sat_round(35'(longint'(5) << 30)), 131071);
    chk("sat_lo_huge", msk_tx_pkg::sat_round(35'(-(longint'(5) << 30))), -131072);
    chk("sat_hi_edge", msk_tx_pkg::sat_round(35'((longint'(131071) << 15) + 16384)), 131071);
    chk("rnd_below",   msk_tx_pkg::sat_round(35'((longint'(131070) << 15) + 16383)), 131070);
    chk("rnd_up",      msk_tx_pkg::sat_round(35'((longint'(131070) << 15) + 16384)), 131071);
    chk("sat_lo_edge", msk_tx_pkg::sat_round(35'(-(longint'(131072) << 15) - 16385)), -131072);
    chk("rnd_neg_half", msk_tx_pkg::sat_round(35'(-16384)), 0);
    chk("rnd_neg_more", msk_tx_pkg::sat_round(35'(-16385)), -1);

    // Underflow: stop feeding symbols mid-stream.
    repeat (2) step(1, 0, 0, 0, 0);
    step(0, 1, 5000, -3000, 0);
    for (int n = 0; n < 25; n++) step(0, 1, 5000 + n, -3000 - n, 1);
    for (int n = 25; n < 45; n++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("underflow_before", underflow_o, 0);
    for (int n = 45; n < 62; n++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("underflow_after", underflow_o, 1);
    for (int n = 0; n < 30; n++) step(0, 0, 0, 0, 1);

    repeat (4) step(0, 0, 0, 0, 0);
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
